// File: rtl/flit_tx_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flit_tx_reader_pkg : shared sizing for the flit transmit read path    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package flit_tx_reader_pkg;

    localparam int SKID_DEPTH      = 2;
    localparam int FLIT_DATA_WIDTH = 32;
    localparam int OCC_WIDTH       = $clog2(SKID_DEPTH + 1);

    typedef logic [OCC_WIDTH-1:0] occ_t;

endpackage
`default_nettype wire

// File: rtl/flit_skid2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flit_skid2 : 2-entry shift skid, e0 is always the head                |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module flit_skid2
    import flit_tx_reader_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output occ_t                  occ_o
);

    occ_t                  occ_q, occ_d;
    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q + {{(OCC_WIDTH-1){1'b0}}, push_i} - {{(OCC_WIDTH-1){1'b0}}, pop_i};
        if (pop_i) begin
            e0_d = e1_q;
        end
        // After a same-cycle pop the head slot is free again, so the arrival takes it.
        if (push_i) begin
            if ((occ_q == '0) || ((occ_q == occ_t'(1)) && pop_i)) begin
                e0_d = push_data_i;
            end else begin
                e1_d = push_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        e0_q <= e0_d;
        e1_q <= e1_d;
    end

    assign head_data_o = e0_q;
    assign occ_o       = occ_q;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && (occ_q == occ_t'(SKID_DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop_i && (occ_q == '0)));
`endif

endmodule
`default_nettype wire

// File: rtl/flit_tx_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flit_tx_reader : drains a flit FIFO onto a valid/ready transmit link  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module flit_tx_reader
    import flit_tx_reader_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en_i,
    input  logic                  fifo_not_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic [CNT_WIDTH-1:0]  tx_count_o,
    output logic                  busy_o
);

    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] tx_count_q, tx_count_d;
    occ_t                 occ;
    logic                 pop;
    logic [OCC_WIDTH:0]   credit_used;

    assign tx_valid_o = (occ != '0);
    assign pop        = tx_valid_o & tx_ready_i;

    // Skid slots committed after this edge; a read is only issued if it has a slot.
    assign credit_used = {1'b0, occ}
                       + {{OCC_WIDTH{1'b0}}, inflight_q}
                       - {{OCC_WIDTH{1'b0}}, pop};

    always_comb begin
        fifo_rd_en_o = !rst && tx_en_i && fifo_not_empty_i
                       && (credit_used < (OCC_WIDTH+1)'(SKID_DEPTH));
        inflight_d   = fifo_rd_en_o;
        tx_count_d   = tx_count_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            tx_count_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            tx_count_q <= tx_count_d;
        end
    end

    flit_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (fifo_rd_data_i),
        .pop_i       (pop),
        .head_data_o (tx_data_o),
        .occ_o       (occ)
    );

    assign tx_count_o = tx_count_q;
    assign busy_o     = inflight_q | (occ != '0);

endmodule
`default_nettype wire

// File: tb/tb_flit_tx_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_flit_tx_reader : FIFO model + scoreboard bench for flit_tx_reader  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_flit_tx_reader;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_en = 1'b0;
    logic          fifo_ne = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] tx_data;
    logic [CW-1:0] tx_count;
    logic          busy;

    int n_total = 0;
    int n_bad   = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] cnt_model = '0;
    int            hs_seen = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    flit_tx_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .tx_en_i          (tx_en),
        .fifo_not_empty_i (fifo_ne),
        .fifo_rd_en_o     (fifo_rd_en),
        .fifo_rd_data_i   (fifo_rd_data),
        .tx_valid_o       (tx_valid),
        .tx_ready_i       (tx_ready),
        .tx_data_o        (tx_data),
        .tx_count_o       (tx_count),
        .busy_o           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Registered-read FIFO: data appears the cycle after rd_en, occupancy seen next cycle.
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            fifo_ne <= 1'b0;
        end else if (fifo_rd_en) begin
            if (fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
            fifo_ne <= (fifo_q.size() != 0);
        end
    end

    task automatic push_flit(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        fifo_ne = 1'b1;
    endtask

    // Monitor: scoreboard, counter model and stall stability.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            cnt_model  = '0;
            prev_stall = 1'b0;
        end else begin
            chk("count", {16'h0, tx_count}, {16'h0, cnt_model});
            if (prev_stall) begin
                chk("stall_valid", {31'h0, tx_valid}, 32'h1);
                chk("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("extra_flit", tx_data, 32'hDEAD_BEEF);
                else                   chk("data", tx_data, exp_q.pop_front());
                cnt_model = cnt_model + 1'b1;
                hs_seen++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // Inputs change on the falling edge; checks happen 1 unit later.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < max) begin
            cyc();
            n++;
        end
        if (n >= max) chk(tag, 32'h0, 32'h1);
    endtask

    int rd_cnt;
    int gaps;
    int hs0;

    initial begin
        logic [7:0] exp_rd, exp_vl, exp_bz;
        exp_rd = 8'b0000_1111;
        exp_vl = 8'b0011_1100;
        exp_bz = 8'b0011_1110;

        // reset state
        rst = 1'b1;
        cyc(); cyc();
        chk("rst_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_busy",  {31'h0, busy}, 32'h0);
        chk("rst_count", {16'h0, tx_count}, 32'h0);
        chk("rst_rden",  {31'h0, fifo_rd_en}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // 1: four preloaded flits, latency and back-to-back delivery
        for (int i = 0; i < 4; i++) push_flit(32'hA0 + i);
        tx_ready = 1'b1;
        cyc();
        @(negedge clk); tx_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t1_rden",  {31'h0, fifo_rd_en}, {31'h0, exp_rd[k]});
            chk("t1_valid", {31'h0, tx_valid},   {31'h0, exp_vl[k]});
            chk("t1_busy",  {31'h0, busy},       {31'h0, exp_bz[k]});
            if (k >= 2 && k <= 5) chk("t1_data", tx_data, 32'hA0 + k - 2);
            @(negedge clk);
        end
        #1;
        chk("t1_count", {16'h0, tx_count}, 32'd4);

        // 2: backpressure with eight queued
        @(negedge clk); tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_flit(32'hB0 + i);
        rd_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (fifo_rd_en) rd_cnt++;
            if (k >= 2) chk("t2_hold", tx_data, 32'hB0);
            @(negedge clk);
        end
        chk("t2_reads", rd_cnt, 32'd2);
        tx_ready = 1'b1;
        gaps = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (!tx_valid) gaps++;
            @(negedge clk);
        end
        chk("t2_gaps", gaps, 32'd0);
        drain("t2_timeout", 20);
        chk("t2_count", {16'h0, tx_count}, 32'd12);

        // 3: toggling ready
        hs0 = hs_seen;
        @(negedge clk);
        for (int i = 0; i < 6; i++) push_flit(32'hC0 + i);
        for (int k = 0; k < 24; k++) begin
            tx_ready = ~k[0];
            #1;
            @(negedge clk);
        end
        tx_ready = 1'b1;
        drain("t3_timeout", 20);
        chk("t3_delivered", hs_seen - hs0, 32'd6);
        chk("t3_count", {16'h0, tx_count}, 32'd18);

        // 4: tx_en dropped right after a read issue
        @(negedge clk); tx_en = 1'b0;
        for (int i = 0; i < 3; i++) push_flit(32'hD0 + i);
        cyc();
        @(negedge clk); tx_en = 1'b1;
        #1;
        chk("t4_first_rd", {31'h0, fifo_rd_en}, 32'h1);
        hs0 = hs_seen;
        @(negedge clk); tx_en = 1'b0;
        rd_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (fifo_rd_en) rd_cnt++;
            @(negedge clk);
        end
        chk("t4_no_rd", rd_cnt, 32'd0);
        chk("t4_one_flit", hs_seen - hs0, 32'd1);
        tx_en = 1'b1;
        drain("t4_timeout", 20);

        // 6: reset while the skid holds flits and a read is in flight
        @(negedge clk); tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_flit(32'hE0 + i);
        cyc(); cyc();
        @(negedge clk); rst = 1'b1;
        #1;
        chk("t6_rden_in_rst", {31'h0, fifo_rd_en}, 32'h0);
        @(negedge clk);
        #1;
        chk("t6_valid", {31'h0, tx_valid}, 32'h0);
        chk("t6_busy",  {31'h0, busy}, 32'h0);
        chk("t6_count", {16'h0, tx_count}, 32'h0);
        chk("t6_rden",  {31'h0, fifo_rd_en}, 32'h0);
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        tx_ready = 1'b1;
        push_flit(32'h55);
        drain("t6_timeout", 20);
        chk("t6_count1", {16'h0, tx_count}, 32'd1);

        // 5: counter wrap
        @(negedge clk);
        for (int i = 0; i < 65534; i++) push_flit(i);
        drain("t5_timeout", 66000);
        chk("t5_allones", {16'h0, tx_count}, 32'hFFFF);
        @(negedge clk);
        push_flit(32'h77);
        drain("t5_timeout2", 20);
        chk("t5_wrap", {16'h0, tx_count}, 32'h0);

        cyc();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
